// File: rtl/mux_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mux_scan_pkg
// Description : Shared constants and state type for the mux scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_scan_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/mux_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface   : mux_scan_ctrl_if
// Description : Scan request/response bundle and mux select/return path.
//               The parity signal exists only with MUX_SCAN_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_scan_ctrl_if
    import mux_scan_pkg::*;
();

    logic             start;
    logic             abort;
    logic             f_in;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             done;
    logic [NCH-1:0]   data;
`ifdef MUX_SCAN_PARITY_EN
    logic             parity;

    modport master (output start, abort, f_in, input sel, busy, done, data, parity);
    modport slave  (input start, abort, f_in, output sel, busy, done, data, parity);
`else
    modport master (output start, abort, f_in, input sel, busy, done, data);
    modport slave  (input start, abort, f_in, output sel, busy, done, data);
`endif

endinterface
`default_nettype wire

// File: rtl/mux_scan_ctrl_dwell_cnt.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_dwell_cnt
// Description : Dwell counter; flags the last cycle of each channel dwell.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_dwell_cnt #(
    parameter int unsigned DWELL = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clr,
    input  wire logic en,
    output logic      last
);

    localparam int CW = (DWELL < 1) ? 1 : $clog2(DWELL + 1);
    localparam logic [CW-1:0] LAST_VAL = CW'(DWELL - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign last = (cnt_q == LAST_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_ctrl
// Description : Steps a 4:1 mux select through all channels, samples the mux
//               output after each dwell and presents the assembled word with
//               a done pulse. Optional parity output via MUX_SCAN_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned DWELL = 2
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    mux_scan_ctrl_if.slave bus
);

    scan_state_t      state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [NCH-1:0]   shadow_q, shadow_d;
    logic [NCH-1:0]   data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_clr, cnt_en, cnt_last;
`ifdef MUX_SCAN_PARITY_EN
    logic             parity_q, parity_d;

    assign bus.parity = parity_q;
`endif

    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.data = data_q;

    mux_scan_dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .last  (cnt_last)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_clr  = 1'b1;
        cnt_en   = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                sel_d  = '0;
                busy_d = 1'b0;
                state_d = IDLE;
                // abort outranks a simultaneous start
                if (bus.start && !bus.abort) begin
                    state_d  = SCAN;
                    shadow_d = '0;
                    busy_d   = 1'b1;
                end
            end
            SCAN: begin
                if (bus.abort) begin
                    state_d  = IDLE;
                    sel_d    = '0;
                    busy_d   = 1'b0;
                    shadow_d = '0;
                end else begin
                    cnt_clr = 1'b0;
                    cnt_en  = 1'b1;
                    if (cnt_last) begin
                        shadow_d[sel_q] = bus.f_in;
                        if (sel_q == SEL_W'(NCH - 1)) begin
                            state_d = DONE;
                            data_d  = shadow_d;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
                            parity_d = ^shadow_d;
`endif
                        end else begin
                            sel_d = sel_q + SEL_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MUX_SCAN_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_ctrl
// Description : Self-checking bench; two controllers (DWELL=2 and DWELL=1)
//               against a transaction-level timing model of the scan.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_ctrl;

    localparam int DA = 2;
    localparam int DB = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux_scan_ctrl_if ifa ();
    mux_scan_ctrl_if ifb ();

    logic [3:0] ia, ib;
    assign ifa.f_in = ia[ifa.sel];
    assign ifb.f_in = ib[ifb.sel];

    mux_scan_ctrl #(.DWELL(DA)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    mux_scan_ctrl #(.DWELL(DB)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    int n_chk  = 0;
    int n_pass = 0;
    int exp_data [2] = '{0, 0};

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic sample(input int w, output int s, output int b, output int dn,
                          output int dt, output int p);
        if (w == 0) begin
            s = int'(ifa.sel); b = int'(ifa.busy); dn = int'(ifa.done); dt = int'(ifa.data);
`ifdef MUX_SCAN_PARITY_EN
            p = int'(ifa.parity);
`else
            p = 0;
`endif
        end else begin
            s = int'(ifb.sel); b = int'(ifb.busy); dn = int'(ifb.done); dt = int'(ifb.data);
`ifdef MUX_SCAN_PARITY_EN
            p = int'(ifb.parity);
`else
            p = 0;
`endif
        end
    endtask

    task automatic drive(input int w, input logic st, input logic ab);
        if (w == 0) begin ifa.start = st; ifa.abort = ab; end
        else        begin ifb.start = st; ifb.abort = ab; end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Idle cycles: controller must sit at channel 0, not busy, word held
    task automatic idle(input int w, input int n);
        int s, b, dn, dt, p;
        drive(w, 1'b0, 1'b0);
        repeat (n) begin
            step();
            sample(w, s, b, dn, dt, p);
            chk("idle_sel", s, 0);
            chk("idle_busy", b, 0);
            chk("idle_done", dn, 0);
            chk("idle_data", dt, exp_data[w]);
        end
    endtask

    // One scan accepted at the next edge; optionally aborted on first cycle of channel abort_sel
    task automatic scan(input int w, input logic [3:0] iv, input bit keep, input int abort_sel);
        int d, s, b, dn, dt, p;
        d = (w == 0) ? DA : DB;
        if (w == 0) ia = iv; else ib = iv;
        drive(w, 1'b1, 1'b0);
        step();
        if (!keep) drive(w, 1'b0, 1'b0);
        for (int k = 0; k < 4 * d; k++) begin
            sample(w, s, b, dn, dt, p);
            chk("scan_sel", s, k / d);
            chk("scan_busy", b, 1);
            chk("scan_done", dn, 0);
            chk("scan_data_hold", dt, exp_data[w]);
            if (abort_sel >= 0 && k == abort_sel * d) begin
                drive(w, 1'b1, 1'b1);
                step();
                sample(w, s, b, dn, dt, p);
                chk("abort_sel", s, 0);
                chk("abort_busy", b, 0);
                chk("abort_done", dn, 0);
                chk("abort_data", dt, exp_data[w]);
                step();
                sample(w, s, b, dn, dt, p);
                chk("abort_start_busy", b, 0);
                chk("abort_start_sel", s, 0);
                chk("abort_start_done", dn, 0);
                drive(w, 1'b0, 1'b0);
                return;
            end
            step();
        end
        sample(w, s, b, dn, dt, p);
        chk("done_pulse", dn, 1);
        chk("done_data", dt, int'(iv));
        chk("done_busy", b, 0);
`ifdef MUX_SCAN_PARITY_EN
        chk("done_parity", p, int'(^iv));
`endif
        exp_data[w] = int'(iv);
    endtask

    initial begin
        int s, b, dn, dt, p;
        int w, ab;
        bit keep;
        logic [3:0] iv;

        rst_n = 1'b0;
        ia = 4'h0;
        ib = 4'h0;
        drive(0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0);
        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            sample(i, s, b, dn, dt, p);
            chk("rst_sel", s, 0);
            chk("rst_busy", b, 0);
            chk("rst_done", dn, 0);
            chk("rst_data", dt, 0);
            chk("rst_parity", p, 0);
        end
        rst_n = 1'b1;
        step();

        // Directed cases
        scan(0, 4'b1010, 1'b0, -1);
        idle(0, 2);
        scan(1, 4'b0111, 1'b0, -1);
        idle(1, 2);

        // Back-to-back with start held: no idle cycle between scans
        scan(0, 4'b0001, 1'b1, -1);
        scan(0, 4'b1000, 1'b1, -1);
        idle(0, 1);

        // Abort while on channel 2, then start+abort in idle ignored
        scan(0, 4'b0101, 1'b0, -1);
        idle(0, 1);
        scan(0, 4'b1110, 1'b0, 2);
        idle(0, 1);

        // Asynchronous reset while on channel 1
        ia = 4'b0011;
        drive(0, 1'b1, 1'b0);
        step();
        drive(0, 1'b0, 1'b0);
        repeat (DA) step();
        sample(0, s, b, dn, dt, p);
        chk("pre_rst_sel", s, 1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            sample(i, s, b, dn, dt, p);
            chk("async_rst_sel", s, 0);
            chk("async_rst_busy", b, 0);
            chk("async_rst_done", dn, 0);
            chk("async_rst_data", dt, 0);
            chk("async_rst_parity", p, 0);
        end
        exp_data[0] = 0;
        exp_data[1] = 0;
        step();
        rst_n = 1'b1;
        step();
        scan(0, 4'b0110, 1'b0, -1);
        idle(0, 1);

        // Randomized scans on either controller
        for (int it = 0; it < 16; it++) begin
            w    = int'($urandom_range(0, 1));
            iv   = 4'($urandom);
            keep = 1'($urandom_range(0, 1));
            ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            scan(w, iv, keep, ab);
            if (keep && ab < 0) scan(w, 4'($urandom), 1'b1, -1);
            idle(w, int'($urandom_range(1, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
